// File: rtl/obi_tmr_voter.sv
// Shared OBI data-port types and the TMR majority voter that sits between the three
// lockstep harts and the single bus master port.

package obi_tmr_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// obi_tmr_voter: votes the three hart requests into one bus request, broadcasts the bus
// response, tracks outstanding transactions and keeps sticky divergence status.
module obi_tmr_voter
    import obi_tmr_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ERR_CNT_W       = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  obi_req_t  [2:0]      core_req_i,
    output obi_resp_t [2:0]      core_resp_o,
    output obi_req_t             bus_req_o,
    input  obi_resp_t            bus_resp_i,
    input  logic                 clear_i,
    output logic                 mismatch_o,
    output logic [2:0]           faulty_core_o,
    output logic                 uncorrectable_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 proto_err_o,
    output logic                 irq_o
);

    localparam logic [2:0] MaxOut = 3'(MAX_OUTSTANDING);

    // Masked compare keys: fields that carry no meaning are zeroed so that stale
    // address/data on idle or read cycles can never cause a false mismatch.
    obi_req_t key [3];

    // Vote results
    obi_req_t   voted;
    logic [2:0] minority;
    logic       vote_mismatch;
    logic       vote_uncorr;
    logic       eq01, eq02, eq12;

    // Transaction tracking
    logic [2:0] outst_q, outst_d;
    logic       full;
    logic       bus_req_vld;
    logic       issue;
    logic       rsp_fwd;
    logic       rsp_spurious;

    // Status registers
    logic                 mismatch_q, mismatch_d;
    logic [2:0]           faulty_q, faulty_d;
    logic                 uncorr_q, uncorr_d;
    logic                 proto_q, proto_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Build the per-hart compare keys with don't-care fields masked
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            key[i]       = '0;
            key[i].req   = core_req_i[i].req;
            if (core_req_i[i].req) begin
                key[i].addr = core_req_i[i].addr;
                key[i].we   = core_req_i[i].we;
                key[i].be   = core_req_i[i].be;
                if (core_req_i[i].we) begin
                    key[i].wdata = core_req_i[i].wdata;
                end
            end
        end
    end

    assign eq01 = (key[0] == key[1]);
    assign eq02 = (key[0] == key[2]);
    assign eq12 = (key[1] == key[2]);

    // Majority vote; all-idle cycles yield equal (zero) keys and never mismatch
    always_comb begin
        voted         = key[0];
        minority      = 3'b000;
        vote_mismatch = 1'b0;
        vote_uncorr   = 1'b0;
        if (!(eq01 && eq12)) begin
            vote_mismatch = 1'b1;
            if (eq01) begin
                minority = 3'b100;
            end else if (eq02) begin
                minority = 3'b010;
            end else if (eq12) begin
                minority = 3'b001;
                voted    = key[1];
            end else begin
                // No majority: hart 0 is forwarded so the bus still makes progress
                vote_uncorr = 1'b1;
            end
        end
    end

    assign full = (outst_q == MaxOut);

    // Reset gates the request so nothing reaches the bus while the tracker is held
    assign bus_req_vld  = voted.req && !full && rst_ni;
    assign issue        = bus_req_vld && bus_resp_i.gnt;
    assign rsp_fwd      = bus_resp_i.rvalid && (outst_q != 3'd0);
    assign rsp_spurious = bus_resp_i.rvalid && (outst_q == 3'd0);

    // Bus request: voted fields with the request qualified by the outstanding limit
    always_comb begin
        bus_req_o     = voted;
        bus_req_o.req = bus_req_vld;
    end

    // Broadcast grant and response to all harts; unexpected responses are swallowed
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            core_resp_o[i]        = '0;
            core_resp_o[i].gnt    = issue;
            core_resp_o[i].rvalid = rsp_fwd;
            core_resp_o[i].rdata  = rsp_fwd ? bus_resp_i.rdata : 32'h0;
        end
    end

    // Outstanding counter next state; a simultaneous issue and response cancel out
    always_comb begin
        outst_d = outst_q;
        if (issue && !rsp_fwd) begin
            outst_d = outst_q + 3'd1;
        end else if (rsp_fwd && !issue) begin
            outst_d = outst_q - 3'd1;
        end
    end

    // Status next state; an event in the clear cycle survives the clear
    always_comb begin
        mismatch_d = vote_mismatch;
        faulty_d   = faulty_q | minority;
        uncorr_d   = uncorr_q | vote_uncorr;
        proto_d    = proto_q | rsp_spurious;
        err_cnt_d  = err_cnt_q;
        if (vote_mismatch && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        if (clear_i) begin
            faulty_d  = minority;
            uncorr_d  = vote_uncorr;
            proto_d   = rsp_spurious;
            err_cnt_d = vote_mismatch ? ERR_CNT_W'(1) : '0;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q    <= 3'd0;
            mismatch_q <= 1'b0;
            faulty_q   <= 3'b000;
            uncorr_q   <= 1'b0;
            proto_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            outst_q    <= outst_d;
            mismatch_q <= mismatch_d;
            faulty_q   <= faulty_d;
            uncorr_q   <= uncorr_d;
            proto_q    <= proto_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign mismatch_o      = mismatch_q;
    assign faulty_core_o   = faulty_q;
    assign uncorrectable_o = uncorr_q;
    assign proto_err_o     = proto_q;
    assign err_cnt_o       = err_cnt_q;
    assign irq_o           = (|faulty_q) | uncorr_q | proto_q;

endmodule

// File: tb/tb_obi_tmr_voter.sv
// Directed bench for obi_tmr_voter (MAX_OUTSTANDING=2, ERR_CNT_W=2).
module tb_obi_tmr_voter;
    import obi_tmr_pkg::*;

    logic                 clk;
    logic                 rst_ni;
    obi_req_t  [2:0]      core_req;
    obi_resp_t [2:0]      core_resp;
    obi_req_t             bus_req;
    obi_resp_t            bus_resp;
    logic                 clear;
    logic                 mismatch;
    logic [2:0]           faulty;
    logic                 uncorr;
    logic [1:0]           err_cnt;
    logic                 proto_err;
    logic                 irq;

    int total = 0;
    int bad   = 0;

    obi_tmr_voter #(
        .MAX_OUTSTANDING(2),
        .ERR_CNT_W      (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .core_req_i     (core_req),
        .core_resp_o    (core_resp),
        .bus_req_o      (bus_req),
        .bus_resp_i     (bus_resp),
        .clear_i        (clear),
        .mismatch_o     (mismatch),
        .faulty_core_o  (faulty),
        .uncorrectable_o(uncorr),
        .err_cnt_o      (err_cnt),
        .proto_err_o    (proto_err),
        .irq_o          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic hart(input int i, input logic rq, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d);
        core_req[i].req   = rq;
        core_req[i].addr  = a;
        core_req[i].we    = w;
        core_req[i].be    = b;
        core_req[i].wdata = d;
    endtask

    task automatic all_harts(input logic rq, input logic [31:0] a, input logic w,
                             input logic [3:0] b, input logic [31:0] d);
        for (int i = 0; i < 3; i++) hart(i, rq, a, w, b, d);
    endtask

    task automatic idle();
        all_harts(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus_resp = '0;
        clear    = 1'b0;
    endtask

    task automatic chk_gnt(input string tag, input logic exp);
        for (int i = 0; i < 3; i++) chk(tag, {63'b0, core_resp[i].gnt}, {63'b0, exp});
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d);
        for (int i = 0; i < 3; i++) begin
            chk(tag, {63'b0, core_resp[i].rvalid}, {63'b0, v});
            chk(tag, {32'b0, core_resp[i].rdata}, {32'b0, d});
        end
    endtask

    initial begin
        // Reset with active stimulus: nothing may leak through
        rst_ni = 1'b0;
        idle();
        all_harts(1'b1, 32'h1000, 1'b0, 4'hF, 32'h0);
        bus_resp.gnt    = 1'b1;
        bus_resp.rvalid = 1'b1;
        #2;
        chk("rst_bus_req", bus_req.req, 0);
        chk_gnt("rst_gnt", 1'b0);
        chk_rsp("rst_rvalid", 1'b0, 32'h0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_faulty", faulty, 0);
        chk("rst_uncorr", uncorr, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_irq", irq, 0);
        step();
        idle();
        rst_ni = 1'b1;
        step();

        // Identical reads
        all_harts(1'b1, 32'h0000_1000, 1'b0, 4'hF, 32'h5555_5555);
        bus_resp.gnt = 1'b1;
        settle();
        chk("rd_bus_req", bus_req.req, 1);
        chk("rd_bus_addr", bus_req.addr, 32'h1000);
        chk("rd_bus_wdata_masked", bus_req.wdata, 0);
        chk_gnt("rd_gnt", 1'b1);
        step();
        idle();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hDEAD_BEEF;
        settle();
        chk_rsp("rd_rsp", 1'b1, 32'hDEAD_BEEF);
        chk("rd_mismatch", mismatch, 0);
        step();
        idle();
        settle();
        chk("rd_errcnt", err_cnt, 0);
        chk("rd_proto", proto_err, 0);

        // Single corrupted store on hart 2
        all_harts(1'b1, 32'h0000_0100, 1'b1, 4'hF, 32'h1234_5678);
        hart(2, 1'b1, 32'h0000_0100, 1'b1, 4'hF, 32'h1234_5679);
        settle();
        chk("st_bus_wdata", bus_req.wdata, 32'h1234_5678);
        chk("st_bus_we", bus_req.we, 1);
        chk("st_mismatch_pre", mismatch, 0);
        step();
        idle();
        settle();
        chk("st_mismatch", mismatch, 1);
        chk("st_faulty", faulty, 3'b100);
        chk("st_errcnt", err_cnt, 1);
        chk("st_irq", irq, 1);
        step();
        chk("st_mismatch_pulse", mismatch, 0);
        chk("st_faulty_sticky", faulty, 3'b100);
        clear = 1'b1;
        step();
        clear = 1'b0;
        settle();
        chk("clr_faulty", faulty, 0);
        chk("clr_errcnt", err_cnt, 0);
        chk("clr_irq", irq, 0);

        // Differing wdata on reads is masked and must not mismatch
        all_harts(1'b1, 32'h40, 1'b0, 4'h3, 32'h0);
        hart(1, 1'b1, 32'h40, 1'b0, 4'h3, 32'hFFFF_FFFF);
        step();
        idle();
        settle();
        chk("mask_mismatch", mismatch, 0);

        // Triple divergence
        hart(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'h0);
        hart(1, 1'b1, 32'h20, 1'b0, 4'hF, 32'h0);
        hart(2, 1'b1, 32'h30, 1'b0, 4'hF, 32'h0);
        settle();
        chk("tri_bus_addr", bus_req.addr, 32'h10);
        step();
        idle();
        settle();
        chk("tri_uncorr", uncorr, 1);
        chk("tri_faulty", faulty, 0);
        chk("tri_mismatch", mismatch, 1);
        chk("tri_errcnt", err_cnt, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        settle();
        chk("tri_clr", uncorr, 0);

        // Outstanding limit of two
        all_harts(1'b1, 32'h2000, 1'b0, 4'hF, 32'h0);
        bus_resp.gnt = 1'b1;
        settle();
        chk("lim_req1", bus_req.req, 1);
        step();
        chk("lim_req2", bus_req.req, 1);
        step();
        chk("lim_full_req", bus_req.req, 0);
        chk_gnt("lim_full_gnt", 1'b0);
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hA5A5_0001;
        settle();
        chk("lim_full_req_rv", bus_req.req, 0);
        chk_rsp("lim_rsp", 1'b1, 32'hA5A5_0001);
        step();
        bus_resp.rvalid = 1'b0;
        settle();
        chk("lim_reissue_req", bus_req.req, 1);
        chk_gnt("lim_reissue_gnt", 1'b1);
        step();
        idle();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'h0000_0002;
        settle();
        chk_rsp("lim_drain1", 1'b1, 32'h2);
        step();
        chk_rsp("lim_drain2", 1'b1, 32'h2);
        step();
        idle();
        settle();
        chk("lim_proto", proto_err, 0);

        // Spurious response
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'hBAD0_BAD0;
        settle();
        chk_rsp("spur_rsp", 1'b0, 32'h0);
        step();
        idle();
        settle();
        chk("spur_proto", proto_err, 1);
        chk("spur_irq", irq, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        settle();
        chk("spur_clr", proto_err, 0);
        chk("spur_clr_irq", irq, 0);

        // Reset mid-transaction drops the outstanding read
        all_harts(1'b1, 32'h3000, 1'b0, 4'hF, 32'h0);
        bus_resp.gnt = 1'b1;
        step();
        idle();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = 32'h7777_7777;
        settle();
        chk_rsp("late_rsp", 1'b0, 32'h0);
        step();
        idle();
        settle();
        chk("late_proto", proto_err, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Saturation: hart 1 diverges for five cycles
        all_harts(1'b1, 32'h500, 1'b0, 4'hF, 32'h0);
        hart(1, 1'b1, 32'h504, 1'b0, 4'hF, 32'h0);
        for (int n = 0; n < 5; n++) step();
        chk("sat_errcnt", err_cnt, 3);
        chk("sat_mismatch", mismatch, 1);
        chk("sat_faulty", faulty, 3'b010);
        // Clear coincides with a new mismatch from hart 0
        all_harts(1'b1, 32'h600, 1'b1, 4'hF, 32'h1);
        hart(0, 1'b1, 32'h600, 1'b1, 4'hF, 32'h2);
        clear = 1'b1;
        step();
        idle();
        settle();
        chk("clrmis_errcnt", err_cnt, 1);
        chk("clrmis_faulty", faulty, 3'b001);
        chk("clrmis_mismatch", mismatch, 1);
        chk("clrmis_irq", irq, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
